// File: rtl/weight_dispatcher.sv
// Streams weight rows from the weight buffer to the PE array: credit-limited row reads,
// a fixed-latency valid pipeline to realign read data, and a small row FIFO toward the PEs.
module weight_dispatcher #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 4096,
   parameter int unsigned RD_LAT     = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_start,
   input  logic [ADDR_WIDTH-1:0] in_base_addr,
   input  logic [ADDR_WIDTH:0]   in_num_rows,
   input  logic [7:0]            in_num_passes,
   output logic                  out_busy,
   output logic                  out_done,
   output logic                  out_wb_req,
   output logic [ADDR_WIDTH-1:0] out_wb_addr,
   input  logic [DATA_WIDTH-1:0] in_wb_rdata,
   output logic                  out_pe_valid,
   input  logic                  in_pe_ready,
   output logic [DATA_WIDTH-1:0] out_pe_data,
   output logic                  out_pe_last
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
   localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);
   localparam logic [PtrW-1:0] PtrMax = PtrW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   rows_q, rows_d;
   logic [7:0]            passes_q, passes_d;
   logic [ADDR_WIDTH:0]   row_q, row_d;
   logic [7:0]            pass_q, pass_d;
   logic                  req_q, req_d;
   logic                  req_last_q, req_last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RD_LAT-1:0]     pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0]     pipe_last_q, pipe_last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH:0]   mem_d [FIFO_DEPTH];
   logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]       count_q, count_d;

   logic                  push, pop, credit_ok, try_issue, cur_last;
   logic [CntW-1:0]       inflight;
   logic [ADDR_WIDTH-1:0] cur_base;
   logic [ADDR_WIDTH:0]   cur_rows, cur_row;
   logic [7:0]            cur_passes, cur_pass;
   logic [DATA_WIDTH:0]   head;

   assign push = pipe_vld_q[RD_LAT-1];
   assign pop  = out_pe_valid & in_pe_ready;

   // Reads committed but not yet in the FIFO: the registered request plus the pipeline.
   always_comb begin
      inflight = CntW'(req_q);
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CntW'(pipe_vld_q[i]);
      end
   end

   // A new request may only claim a slot that is free even if the PEs stall from now on.
   assign credit_ok = (count_q + inflight - CntW'(pop)) < Depth;

   always_comb begin
      pipe_vld_d     = '0;
      pipe_last_d    = '0;
      pipe_vld_d[0]  = req_q;
      pipe_last_d[0] = req_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_last_d[i] = pipe_last_q[i-1];
      end
   end

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (push) begin
         mem_d[wptr_q] = {pipe_last_q[RD_LAT-1], in_wb_rdata};
         wptr_d        = (wptr_q == PtrMax) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = (rptr_q == PtrMax) ? '0 : rptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      rows_d     = rows_q;
      passes_d   = passes_q;
      row_d      = row_q;
      pass_d     = pass_q;
      req_d      = 1'b0;
      req_last_d = 1'b0;
      addr_d     = addr_q;
      done_d     = 1'b0;
      try_issue  = 1'b0;
      cur_base   = base_q;
      cur_rows   = rows_q;
      cur_passes = passes_q;
      cur_row    = row_q;
      cur_pass   = pass_q;
      cur_last   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Idle implies an empty FIFO and no reads in flight, so the first read needs no credit check.
            if (in_start && (in_num_rows != '0) && (in_num_passes != '0)) begin
               base_d     = in_base_addr;
               rows_d     = in_num_rows;
               passes_d   = in_num_passes;
               cur_base   = in_base_addr;
               cur_rows   = in_num_rows;
               cur_passes = in_num_passes;
               cur_row    = '0;
               cur_pass   = '0;
               state_d    = StIssue;
               try_issue  = 1'b1;
            end
         end
         StIssue: try_issue = credit_ok;
         StDrain: begin
            if ((inflight == '0) && (count_d == '0)) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (try_issue) begin
         cur_last   = (cur_row == (cur_rows - (ADDR_WIDTH + 1)'(1)));
         req_d      = 1'b1;
         req_last_d = cur_last;
         addr_d     = cur_base + cur_row[ADDR_WIDTH-1:0];
         if (cur_last) begin
            row_d  = '0;
            pass_d = cur_pass + 8'd1;
            if (cur_pass == (cur_passes - 8'd1)) begin
               state_d = StDrain;
            end
         end else begin
            row_d  = cur_row + (ADDR_WIDTH + 1)'(1);
            pass_d = cur_pass;
         end
      end

      busy_d = (state_d != StIdle) || done_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         base_q      <= '0;
         rows_q      <= '0;
         passes_q    <= '0;
         row_q       <= '0;
         pass_q      <= '0;
         req_q       <= 1'b0;
         req_last_q  <= 1'b0;
         addr_q      <= '0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         rows_q      <= rows_d;
         passes_q    <= passes_d;
         row_q       <= row_d;
         pass_q      <= pass_d;
         req_q       <= req_d;
         req_last_q  <= req_last_d;
         addr_q      <= addr_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
      end
   end

   // Row storage needs no reset: the head is gated by the occupancy count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         assert (count_q != Depth) else $error("weight_dispatcher: push into full row FIFO");
      end
   end

   assign head         = mem_q[rptr_q];
   assign out_pe_valid = (count_q != '0);
   assign out_pe_data  = out_pe_valid ? head[DATA_WIDTH-1:0] : '0;
   assign out_pe_last  = out_pe_valid & head[DATA_WIDTH];
   assign out_busy     = busy_q;
   assign out_done     = done_q;
   assign out_wb_req   = req_q;
   assign out_wb_addr  = addr_q;

endmodule

// File: tb/tb_weight_dispatcher.sv
// Scoreboard bench for weight_dispatcher: a fixed-latency weight buffer model feeds the DUT,
// expected addresses and rows are queued at each start and checked as the DUT produces them.
module tb_weight_dispatcher;

   localparam int AW    = 8;
   localparam int DW    = 4096;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_start = 1'b0;
   logic [AW-1:0] in_base_addr = '0;
   logic [AW:0]   in_num_rows = '0;
   logic [7:0]    in_num_passes = '0;
   logic          out_busy, out_done, out_wb_req, out_pe_valid, out_pe_last;
   logic [AW-1:0] out_wb_addr;
   logic [DW-1:0] in_wb_rdata, out_pe_data;
   logic          in_pe_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_xfer_cyc = 0;
   int req_total = 0;
   int xfer_total = 0;
   int done_cnt = 0;
   logic [7:0] salt = 8'h01;

   logic [AW-1:0] addr_q [$];
   logic [DW:0]   exp_q  [$];

   weight_dispatcher #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_start     (in_start),
      .in_base_addr (in_base_addr),
      .in_num_rows  (in_num_rows),
      .in_num_passes(in_num_passes),
      .out_busy     (out_busy),
      .out_done     (out_done),
      .out_wb_req   (out_wb_req),
      .out_wb_addr  (out_wb_addr),
      .in_wb_rdata  (in_wb_rdata),
      .out_pe_valid (out_pe_valid),
      .in_pe_ready  (in_pe_ready),
      .out_pe_data  (out_pe_data),
      .out_pe_last  (out_pe_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] row_data(input logic [AW-1:0] a, input logic [7:0] s);
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) begin
         d[i*32 +: 32] = {a, s, 8'(i), ~a};
      end
      return d;
   endfunction

   // Weight buffer model: data appears LAT cycles after the request, zero otherwise.
   logic [LAT-1:0] m_vld;
   logic [AW-1:0]  m_addr [LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld <= '0;
      end else begin
         m_vld     <= {m_vld[LAT-2:0], out_wb_req};
         m_addr[0] <= out_wb_addr;
         for (int i = 1; i < LAT; i++) m_addr[i] <= m_addr[i-1];
      end
   end
   assign in_wb_rdata = m_vld[LAT-1] ? row_data(m_addr[LAT-1], salt) : '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_wb_req) begin
            req_total++;
            check_eq("addr_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) check_eq("wb_addr", 64'(out_wb_addr), 64'(addr_q.pop_front()));
         end
         if (out_pe_valid && in_pe_ready) begin
            xfer_total++;
            last_xfer_cyc = cyc;
            check_eq("row_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               logic [DW:0] e;
               e = exp_q.pop_front();
               check_eq("pe_data_lo", out_pe_data[63:0], e[63:0]);
               check_eq("pe_data_eq", 64'(out_pe_data == e[DW-1:0]), 64'd1);
               check_eq("pe_last", 64'(out_pe_last), 64'(e[DW]));
            end
         end
         if (out_done) begin
            done_cnt++;
            check_eq("done_lat", 64'(cyc - last_xfer_cyc), 64'd1);
            check_eq("sb_empty_at_done", 64'(exp_q.size()), 64'd0);
            check_eq("busy_at_done", 64'(out_busy), 64'd1);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] r, input logic [7:0] p,
                            input bit expect_run);
      if (expect_run) begin
         for (int pi = 0; pi < int'(p); pi++) begin
            for (int ri = 0; ri < int'(r); ri++) begin
               logic [AW-1:0] a;
               a = b + AW'(ri);
               addr_q.push_back(a);
               exp_q.push_back({ri == int'(r) - 1, row_data(a, salt)});
            end
         end
      end
      step(1);
      in_base_addr  = b;
      in_num_rows   = r;
      in_num_passes = p;
      in_start      = 1'b1;
      step(1);
      in_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rand_ready);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) begin
         if (rand_ready) in_pe_ready = 1'($urandom_range(0, 1));
         step(1);
      end
      in_pe_ready = 1'b1;
      check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
      step(3);
      check_eq("done_once", 64'(done_cnt - d0), 64'd1);
      check_eq("idle_after_done", 64'(out_busy), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 64'(out_busy), 64'd0);
      check_eq({tag, "_done"}, 64'(out_done), 64'd0);
      check_eq({tag, "_req"}, 64'(out_wb_req), 64'd0);
      check_eq({tag, "_addr"}, 64'(out_wb_addr), 64'd0);
      check_eq({tag, "_valid"}, 64'(out_pe_valid), 64'd0);
      check_eq({tag, "_data"}, 64'(out_pe_data != '0), 64'd0);
      check_eq({tag, "_last"}, 64'(out_pe_last), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, reqs, r0, x0, d0, wait_i;
      logic [DW-1:0] exp_row;

      // Reset state
      step(3);
      check_all_zero("rst");
      rst_n = 1'b1;
      step(2);
      check_all_zero("post_rst");

      // Basic run with latency checks
      in_pe_ready = 1'b1;
      salt = 8'h11;
      start_run(8'h10, 9'd4, 8'd1, 1'b1);
      check_eq("basic_busy", 64'(out_busy), 64'd1);
      check_eq("basic_first_req", 64'(out_wb_req), 64'd1);
      lat  = 0;
      reqs = 0;
      while (lat < 20 && !out_pe_valid) begin
         if (lat < 4) reqs += int'(out_wb_req);
         lat++;
         step(1);
      end
      check_eq("first_valid_lat", 64'(lat), 64'(LAT + 1));
      check_eq("basic_back_to_back_reqs", 64'(reqs), 64'd4);
      wait_done(100, 1'b0);

      // Address wrap with two passes
      salt = 8'h22;
      start_run(8'hFE, 9'd3, 8'd2, 1'b1);
      wait_done(200, 1'b0);

      // Backpressure: credits cap outstanding reads at the FIFO depth
      in_pe_ready = 1'b0;
      salt = 8'h33;
      r0 = req_total;
      start_run(8'h20, 9'd16, 8'd1, 1'b1);
      exp_row = row_data(8'h20, salt);
      step(5);
      check_eq("bp_head_early", out_pe_data[63:0], exp_row[63:0]);
      step(14);
      check_eq("bp_reqs", 64'(req_total - r0), 64'(DEPTH));
      check_eq("bp_valid_held", 64'(out_pe_valid), 64'd1);
      check_eq("bp_head_late", out_pe_data[63:0], exp_row[63:0]);
      check_eq("bp_last_held", 64'(out_pe_last), 64'd0);
      in_pe_ready = 1'b1;
      wait_done(300, 1'b0);

      // Command rejection: start while busy, then zero rows / zero passes
      salt = 8'h44;
      start_run(8'h30, 9'd8, 8'd1, 1'b1);
      step(2);
      start_run(8'h80, 9'd2, 8'd1, 1'b0);
      check_eq("busy_on_restart", 64'(out_busy), 64'd1);
      wait_done(200, 1'b0);
      r0 = req_total;
      start_run(8'h50, 9'd0, 8'd1, 1'b0);
      step(3);
      check_eq("rows0_busy", 64'(out_busy), 64'd0);
      start_run(8'h50, 9'd4, 8'd0, 1'b0);
      step(3);
      check_eq("passes0_busy", 64'(out_busy), 64'd0);
      check_eq("rejected_reqs", 64'(req_total - r0), 64'd0);

      // Random ready, long multi-pass run
      salt = 8'h55;
      start_run(8'h00, 9'd256, 8'd3, 1'b1);
      wait_done(20000, 1'b1);

      // Reset mid-run
      salt = 8'h66;
      in_pe_ready = 1'b1;
      x0 = xfer_total;
      d0 = done_cnt;
      start_run(8'h60, 9'd16, 8'd1, 1'b1);
      wait_i = 0;
      while (wait_i < 100 && (xfer_total - x0) < 5) begin
         wait_i++;
         step(1);
      end
      check_eq("mid_xfers", 64'((xfer_total - x0) >= 5), 64'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      addr_q.delete();
      exp_q.delete();
      step(2);
      rst_n = 1'b1;
      step(10);
      check_eq("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
      salt = 8'h77;
      start_run(8'h40, 9'd5, 8'd2, 1'b1);
      wait_done(200, 1'b0);

      check_eq("addr_q_drained", 64'(addr_q.size()), 64'd0);
      check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
